// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster constants and shared types for the VGA timing generator.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Sync windows are half-open: START is the first sync position, END the first one after.
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic [9:0] coord_t;

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Clock-enabled shift register that delays sync bits to match the renderer pixel pipeline.
module sync_delay_line #(
    parameter int               WIDTH     = 2,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
                end else if (ce) begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter for the VGA output: coordinates, blanking, line/frame markers,
// and sync pulses delayed to line up with the renderers' registered colour.
module vga_timing_gen #(
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int SYNC_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        pix_ce,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    import vga_timing_pkg::*;

    localparam coord_t LINE_LEN    = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam coord_t FRAME_LINES = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam coord_t HS_START    = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END      = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START    = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END      = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t      hc;
    coord_t      vc;
    coord_t      hc_next;
    coord_t      vc_next;
    logic        h_wrap;
    logic        v_wrap;
    logic        hsync_raw;
    logic        vsync_raw;
    logic [1:0]  sync_delayed;
    logic [15:0] frame_cnt;

    always_comb begin
        h_wrap  = (hc == LINE_LEN - 10'd1);
        v_wrap  = (vc == FRAME_LINES - 10'd1);
        hc_next = h_wrap ? '0 : hc + 10'd1;
        vc_next = vc;
        if (h_wrap) vc_next = v_wrap ? '0 : vc + 10'd1;
    end

    // Flags are registered from the next-state counters so they change on the same edge as DrawX/DrawY.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc          <= '0;
            vc          <= '0;
            blank       <= 1'b1;
            hsync_raw   <= 1'b1;
            vsync_raw   <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (pix_ce) begin
            hc          <= hc_next;
            vc          <= vc_next;
            blank       <= (hc_next < coord_t'(H_ACTIVE)) && (vc_next < coord_t'(V_ACTIVE));
            hsync_raw   <= !in_window(hc_next, HS_START, HS_END);
            vsync_raw   <= !in_window(vc_next, VS_START, VS_END);
            line_start  <= (hc_next == '0);
            frame_start <= (hc_next == '0) && (vc_next == '0);
            if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    sync_delay_line #(
        .WIDTH     (2),
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (2'b11)
    ) u_sync_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .ce      (pix_ce),
        .din     ({hsync_raw, vsync_raw}),
        .dout    (sync_delayed)
    );

    assign DrawX       = hc;
    assign DrawY       = vc;
    assign hs          = sync_delayed[1];
    assign vs          = sync_delayed[0];
    assign frame_count = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken 32x15 raster so whole frames stay short.
module tb_vga_timing_gen;

    // Reduced raster: hsync low for x in [20,25], vsync low for y in [10,11], 480 cycles per frame.
    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = 32, VT = 15;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic        pix_ce;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    typedef struct {
        int          x;
        int          y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   max_x  = 0;
    int   max_y  = 0;
    int   fs_rises = 0;
    logic fs_prev  = 1'b0;

    int          m_hc, m_vc;
    logic        m_blank, m_ls, m_fs, m_hraw, m_vraw;
    logic [1:0]  m_dly0, m_dly1;
    logic [15:0] m_fc;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_DELAY(2)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .pix_ce      (pix_ce),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .hs          (hs),
        .vs          (vs),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic model_reset();
        m_hc = 0; m_vc = 0; m_fc = '0;
        m_blank = 1'b1; m_ls = 1'b0; m_fs = 1'b0;
        m_hraw = 1'b1; m_vraw = 1'b1;
        m_dly0 = 2'b11; m_dly1 = 2'b11;
    endtask

    task automatic model_step();
        int nh, nv;
        nh = (m_hc == HT-1) ? 0 : m_hc + 1;
        nv = m_vc;
        if (m_hc == HT-1) nv = (m_vc == VT-1) ? 0 : m_vc + 1;
        if (m_hc == HT-1 && m_vc == VT-1) m_fc = m_fc + 16'd1;
        m_dly1  = m_dly0;
        m_dly0  = {m_hraw, m_vraw};
        m_hraw  = !(nh >= 20 && nh <= 25);
        m_vraw  = !(nv >= 10 && nv <= 11);
        m_blank = (nh < 16) && (nv < 8);
        m_ls    = (nh == 0);
        m_fs    = (nh == 0) && (nv == 0);
        m_hc    = nh;
        m_vc    = nv;
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.x = m_hc; e.y = m_vc; e.blank = m_blank;
        e.hs = m_dly1[1]; e.vs = m_dly1[0];
        e.ls = m_ls; e.fs = m_fs; e.fc = m_fc;
        return e;
    endfunction

    task automatic apply_stimulus(input logic ce, input logic rst_n_val);
        @(negedge vga_clk);
        pix_ce  = ce;
        reset_n = rst_n_val;
        if (!rst_n_val) model_reset();
        @(posedge vga_clk);
        if (ce && rst_n_val) model_step();
        #1 exp_q.push_back(cur_exp());
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b1);
    endtask

    task automatic check_val(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic check_output(input exp_t e);
        n_cmp++;
        if (int'(DrawX) != e.x || int'(DrawY) != e.y || blank !== e.blank || hs !== e.hs ||
            vs !== e.vs || line_start !== e.ls || frame_start !== e.fs || frame_count !== e.fc) begin
            n_fail++;
            $display("[TB] FAIL scoreboard @%0t: got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                     $time, DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count,
                     e.x, e.y, e.blank, e.hs, e.vs, e.ls, e.fs, e.fc);
        end
    endtask

    // Monitor: one expected entry is due per pushed cycle, compared mid-cycle on the falling edge.
    always @(negedge vga_clk) begin
        if (exp_q.size() > 0) check_output(exp_q.pop_front());
        if (reset_n === 1'b1) begin
            if (int'(DrawX) > max_x) max_x = int'(DrawX);
            if (int'(DrawY) > max_y) max_y = int'(DrawY);
            if (frame_start === 1'b1 && !fs_prev) fs_rises++;
            fs_prev = frame_start;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b1;
        pix_ce  = 1'b0;
        model_reset();
        #2 reset_n = 1'b0;

        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);

        // First frame from reset: hand-computed edges for blank, hs, vs and the frame marker.
        for (int k = 1; k <= 480; k++) begin
            apply_stimulus(1'b1, 1'b1);
            case (k)
                15:  check_val("blank@x15", int'(blank), 1);
                16:  check_val("blank@x16", int'(blank), 0);
                21:  check_val("hs@21", int'(hs), 1);
                22:  check_val("hs@22", int'(hs), 0);
                27:  check_val("hs@27", int'(hs), 0);
                28:  check_val("hs@28", int'(hs), 1);
                32:  check_val("line_start@32", int'(line_start), 1);
                321: check_val("vs@321", int'(vs), 1);
                322: check_val("vs@322", int'(vs), 0);
                385: check_val("vs@385", int'(vs), 0);
                386: check_val("vs@386", int'(vs), 1);
                479: check_val("frame_start@479", int'(frame_start), 0);
                480: begin
                    check_val("frame_start@480", int'(frame_start), 1);
                    check_val("frame_count@480", int'(frame_count), 1);
                end
                default: ;
            endcase
        end

        // Clock-enable gaps right at the frame wrap.
        run_steps(479);
        check_val("DrawX@end", int'(DrawX), 31);
        check_val("DrawY@end", int'(DrawY), 14);
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        check_val("frame_start held", int'(frame_start), 0);
        check_val("DrawX held", int'(DrawX), 31);
        apply_stimulus(1'b1, 1'b1);
        check_val("frame_start after gap", int'(frame_start), 1);
        check_val("frame_count after gap", int'(frame_count), 2);

        // Asynchronous reset mid-line, between clock edges.
        run_steps(169);
        check_val("DrawX before reset", int'(DrawX), 9);
        check_val("DrawY before reset", int'(DrawY), 5);
        @(negedge vga_clk);
        pix_ce = 1'b1;
        @(posedge vga_clk);
        model_step();
        #2 reset_n = 1'b0;
        model_reset();
        exp_q.push_back(cur_exp());
        #1;
        check_val("reset DrawX", int'(DrawX), 0);
        check_val("reset frame_count", int'(frame_count), 0);
        check_val("reset hs", int'(hs), 1);
        check_val("reset vs", int'(vs), 1);
        check_val("reset blank", int'(blank), 1);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);

        // Frame counter wrap from 0xFFFF.
        run_steps(479);
        @(negedge vga_clk);
        pix_ce = 1'b0;
        #1 force dut.frame_cnt = 16'hFFFF;
        #1 release dut.frame_cnt;
        m_fc = 16'hFFFF;
        check_val("frame_count preset", int'(frame_count), 65535);
        apply_stimulus(1'b1, 1'b1);
        check_val("frame_count wrap", int'(frame_count), 0);
        check_val("frame_start at wrap", int'(frame_start), 1);
        run_steps(5);

        @(negedge vga_clk);
        @(negedge vga_clk);
        check_val("scoreboard drained", exp_q.size(), 0);
        check_val("frame_start count", fs_rises, 3);
        check_val("max DrawX", max_x, HT-1);
        check_val("max DrawY", max_y, VT-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
